// File: rtl/vdic_serial_rx.sv
// Serial frame receiver for the VDIC DUT input port.
// Deserializes 10-bit words (flag, 8 payload bits MSB first, parity) from din
// while enable_n is low. It collects up to MAX_DATA data bytes plus the closing
// command byte, then publishes the whole frame through a valid/ready handshake.
module vdic_serial_rx #(
    parameter int MAX_DATA = 8,
    parameter int CW       = $clog2(MAX_DATA + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_n,
    input  logic                    din,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [7:0]              cmd,
    output logic [8*MAX_DATA-1:0]   data,
    output logic [CW-1:0]           n_data,
    output logic                    parity_err,
    output logic                    overflow_err,
    output logic                    frame_err
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Parity over the 8 payload bits only; the flag bit is not covered.
    function automatic logic payload_parity(input logic [7:0] v);
        return ^v;
    endfunction

    // Write one byte into the working buffer at the given index.
    function automatic logic [8*MAX_DATA-1:0] insert_byte(
        input logic [8*MAX_DATA-1:0] buf_in,
        input logic [CW-1:0]         idx,
        input logic [7:0]            b
    );
        logic [8*MAX_DATA-1:0] r;
        r = buf_in;
        for (int i = 0; i < MAX_DATA; i++) begin
            if (CW'(i) == idx) begin
                r[8*i +: 8] = b;
            end
        end
        return r;
    endfunction

    state_t                  state;
    logic [3:0]              bit_cnt;
    logic [8:0]              shreg;
    logic [8*MAX_DATA-1:0]   buf_data;
    logic [CW-1:0]           buf_n;
    logic                    buf_perr;
    logic                    buf_ovf;

    logic [9:0]              word_s;
    logic                    flag_s;
    logic [7:0]              payload_s;
    logic                    perr_s;
    logic                    buf_full_s;

    // Assemble the word as it would look with the current din as its parity bit.
    always_comb begin
        word_s     = {shreg, din};
        flag_s     = word_s[9];
        payload_s  = word_s[8:1];
        perr_s     = (payload_parity(payload_s) != word_s[0]);
        buf_full_s = (buf_n == CW'(MAX_DATA));
    end

    // Receive FSM: bit shifting, word evaluation, working buffer and published outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= 4'd0;
            shreg        <= 9'd0;
            buf_data     <= '0;
            buf_n        <= '0;
            buf_perr     <= 1'b0;
            buf_ovf      <= 1'b0;
            frame_valid  <= 1'b0;
            cmd          <= 8'd0;
            data         <= '0;
            n_data       <= '0;
            parity_err   <= 1'b0;
            overflow_err <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            // A transfer retires the frame unless a new one is published below.
            if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!enable_n) begin
                        shreg    <= {8'd0, din};
                        bit_cnt  <= 4'd1;
                        buf_data <= '0;
                        buf_n    <= '0;
                        buf_perr <= 1'b0;
                        buf_ovf  <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (enable_n) begin
                        // Mid-word drop, or boundary after data words with no command.
                        frame_valid  <= 1'b1;
                        cmd          <= 8'd0;
                        data         <= buf_data;
                        n_data       <= buf_n;
                        parity_err   <= buf_perr;
                        overflow_err <= buf_ovf;
                        frame_err    <= 1'b1;
                        bit_cnt      <= 4'd0;
                        state        <= IDLE;
                    end else if (bit_cnt == 4'd9) begin
                        bit_cnt <= 4'd0;
                        if (!flag_s) begin
                            if (perr_s) begin
                                buf_perr <= 1'b1;
                            end
                            if (buf_full_s) begin
                                buf_ovf <= 1'b1;
                            end else begin
                                buf_data <= insert_byte(buf_data, buf_n, payload_s);
                                buf_n    <= buf_n + CW'(1);
                            end
                        end else begin
                            // Command word closes the frame; next low enable_n starts a new one.
                            frame_valid  <= 1'b1;
                            cmd          <= payload_s;
                            data         <= buf_data;
                            n_data       <= buf_n;
                            parity_err   <= buf_perr | perr_s;
                            overflow_err <= buf_ovf;
                            frame_err    <= 1'b0;
                            state        <= IDLE;
                        end
                    end else begin
                        shreg   <= {shreg[7:0], din};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdic_serial_rx.sv
// Directed bench for vdic_serial_rx: stimulus pushes expected frames into a
// queue, a separate monitor pops and compares on every valid/ready transfer.
module tb_vdic_serial_rx;

    localparam int MAX_DATA = 8;
    localparam int CW       = $clog2(MAX_DATA + 1);

    typedef struct {
        logic [7:0]            cmd;
        logic [8*MAX_DATA-1:0] data;
        logic [CW-1:0]         n;
        logic                  perr;
        logic                  ovf;
        logic                  ferr;
    } frame_t;

    logic                  clk;
    logic                  rst_n;
    logic                  enable_n;
    logic                  din;
    logic                  frame_valid;
    logic                  frame_ready;
    logic [7:0]            cmd;
    logic [8*MAX_DATA-1:0] data;
    logic [CW-1:0]         n_data;
    logic                  parity_err;
    logic                  overflow_err;
    logic                  frame_err;

    int     total = 0;
    int     bad   = 0;
    frame_t exp_q[$];

    vdic_serial_rx #(.MAX_DATA(MAX_DATA)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_n     (enable_n),
        .din          (din),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .cmd          (cmd),
        .data         (data),
        .n_data       (n_data),
        .parity_err   (parity_err),
        .overflow_err (overflow_err),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] c, input logic [63:0] d, input int n,
                        input logic pe, input logic oe, input logic fe);
        frame_t f;
        f.cmd  = c;
        f.data = d;
        f.n    = CW'(n);
        f.perr = pe;
        f.ovf  = oe;
        f.ferr = fe;
        exp_q.push_back(f);
    endtask

    // Drive the first nbits of a word; inv flips the parity bit.
    task automatic send_word(input logic flag, input logic [7:0] p, input logic inv,
                             input int nbits, input logic no_first_wait);
        logic [9:0] w;
        w = {flag, p, (^p) ^ inv};
        for (int i = 0; i < nbits; i++) begin
            if (!(no_first_wait && i == 0)) @(negedge clk);
            enable_n = 1'b0;
            din      = w[9-i];
        end
    endtask

    task automatic go_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            enable_n = 1'b1;
            din      = 1'b0;
        end
    endtask

    // Monitor: compare every transfer against the oldest expected frame.
    always @(negedge clk) begin
        frame_t f;
        #3;
        if (rst_n && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", {cmd, n_data}, 0);
            end else begin
                f = exp_q.pop_front();
                chk("cmd",          cmd,          f.cmd);
                chk("data",         data,         f.data);
                chk("n_data",       n_data,       f.n);
                chk("parity_err",   parity_err,   f.perr);
                chk("overflow_err", overflow_err, f.ovf);
                chk("frame_err",    frame_err,    f.ferr);
            end
        end
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        enable_n    = 1'b1;
        din         = 1'b0;
        frame_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {frame_valid, cmd, data, n_data, parity_err, overflow_err, frame_err}, 0);
        rst_n = 1'b1;
        go_idle(2);

        // Two data words and a command; valid appears 30 cycles after the first bit.
        push(8'h01, 64'h2211, 2, 1'b0, 1'b0, 1'b0);
        send_word(1'b0, 8'h11, 1'b0, 10, 1'b0);
        send_word(1'b0, 8'h22, 1'b0, 10, 1'b0);
        send_word(1'b1, 8'h01, 1'b0, 9, 1'b0);
        chk("valid_before_last_bit", frame_valid, 1'b0);
        send_word(1'b1, 8'h01, 1'b0, 0, 1'b0);
        @(negedge clk);
        din = 1'b1;           // parity of 0x01
        @(negedge clk);
        enable_n = 1'b1;
        chk("latency_valid", frame_valid, 1'b1);
        @(negedge clk);
        chk("valid_one_cycle", frame_valid, 1'b0);
        go_idle(2);

        // Reset in the middle of a frame: nothing published, outputs cleared.
        send_word(1'b0, 8'h55, 1'b0, 10, 1'b0);
        send_word(1'b0, 8'h66, 1'b0, 3, 1'b0);
        @(negedge clk);
        rst_n    = 1'b0;
        enable_n = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {frame_valid, n_data, cmd}, 0);
        rst_n = 1'b1;
        go_idle(2);

        // Command-only frame, then the same with a bad parity bit.
        push(8'h05, 64'h0, 0, 1'b0, 1'b0, 1'b0);
        send_word(1'b1, 8'h05, 1'b0, 10, 1'b0);
        go_idle(3);
        push(8'h05, 64'h0, 0, 1'b1, 1'b0, 1'b0);
        send_word(1'b1, 8'h05, 1'b1, 10, 1'b0);
        go_idle(3);

        // Nine data words overflow an 8-byte buffer.
        push(8'h10, 64'h0807060504030201, 8, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) send_word(1'b0, 8'(i), 1'b0, 10, 1'b0);
        send_word(1'b1, 8'h10, 1'b0, 10, 1'b0);
        go_idle(3);

        // Enable drops mid-word after one full data word.
        push(8'h00, 64'hAA, 1, 1'b0, 1'b0, 1'b1);
        send_word(1'b0, 8'hAA, 1'b0, 10, 1'b0);
        send_word(1'b0, 8'h33, 1'b0, 4, 1'b0);
        go_idle(3);

        // Enable drops at a word boundary with no command.
        push(8'h00, 64'h3412, 2, 1'b0, 1'b0, 1'b1);
        send_word(1'b0, 8'h12, 1'b0, 10, 1'b0);
        send_word(1'b0, 8'h34, 1'b0, 10, 1'b0);
        go_idle(3);

        // Back-to-back frames while the core is not ready: second overwrites first.
        frame_ready = 1'b0;
        push(8'h02, 64'h0, 0, 1'b0, 1'b0, 1'b0);
        send_word(1'b1, 8'h01, 1'b0, 10, 1'b0);
        @(negedge clk);
        chk("b2b_first_published", {frame_valid, cmd}, {1'b1, 8'h01});
        send_word(1'b1, 8'h02, 1'b0, 10, 1'b1);
        @(negedge clk);
        enable_n = 1'b1;
        chk("b2b_second_published", {frame_valid, cmd}, {1'b1, 8'h02});
        frame_ready = 1'b1;
        @(negedge clk);
        chk("valid_drop_after_ready", frame_valid, 1'b0);
        go_idle(3);

        chk("all_frames_seen", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vdic_serial_rx.md
# vdic_serial_rx

Serial frame receiver for the VDIC DUT input port. It deserializes the `din`/`enable_n` bitstream into 9-bit words: a flag bit plus 8 payload bits, each followed by a parity bit. It collects up to MAX_DATA data bytes and the terminating command byte, then presents the complete frame to the core through a valid/ready handshake. It is the receiving end of the word stream the testbench BFM drives.

## Interface
- MAX_DATA, 8: maximum data bytes per frame. The count width is $clog2(MAX_DATA+1).
- clk  in  1  system clock; all sampling on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable_n  in  1  frame enable, active low; low for every bit of every word in a frame
- din  in  1  serial data, MSB first, sampled on posedge while enable_n=0
- frame_valid  out  1  completed frame available
- frame_ready  in  1  core accepts frame; transfer when frame_valid && frame_ready
- cmd  out  8  command byte of the frame
- data  out  8*MAX_DATA  data bytes; byte i at [8i+7:8i]; unused bytes 0
- n_data  out  4  number of data bytes stored (0..MAX_DATA)
- parity_err  out  1  at least one word in the frame failed parity
- overflow_err  out  1  more than MAX_DATA data words received
- frame_err  out  1  enable_n deasserted mid-word, or frame ended without a command word

## Operation
- Word format, 10 serial bits: b9 = flag (0 data, 1 command), b8..b1 = payload MSB first, b0 = parity.
- Parity: b0 must equal the XOR of the 8 payload bits. The flag bit is excluded.
- States:
  - IDLE: waits for enable_n=0 and captures the first bit.
  - SHIFT: a bit counter runs 0..9.
  - EVAL: combinational on the parity cycle, not a separate clock state.
- Word completion, when the 10th bit is sampled:
  - Data word, n_data < MAX_DATA: store payload at index n_data, n_data++.
  - Data word, n_data = MAX_DATA: drop payload, set overflow_err.
  - Parity mismatch: set parity_err. The word is still stored or executed.
  - Command word: copy cmd, data, n_data and flags to the output registers and assert frame_valid.
- After a command word:
  - If enable_n=0 on the next posedge, that bit is b9 of a new frame. Back-to-back frames are legal.
  - Otherwise return to IDLE.
- Framing errors:
  - enable_n=1 with the bit counter at 1..9: abort.
  - enable_n=1 at a word boundary after at least one data word and no command: abort.
  - On abort: publish a frame with frame_err=1, cmd=0 and the data received so far; assert frame_valid; go to IDLE.
- Output registers are separate from the working buffer. Reception continues while frame_valid is pending.
- A new frame completing while frame_valid=1 and not accepted overwrites the outputs and keeps frame_valid=1. The lost frame is not flagged.
- On a transfer with no new completion in the same cycle, frame_valid drops on the next posedge.
- If a transfer and a new completion happen in the same cycle, the new frame wins and frame_valid stays 1.
- The working buffer clears (n_data=0, flags=0, data=0) at the start of each frame.

## Timing
- Reset (asynchronous, rst_n=0): state IDLE, bit counter 0.
  - frame_valid=0, cmd=0, data=0, n_data=0, parity_err=0, overflow_err=0, frame_err=0.
  - Takes effect immediately and aborts any frame in progress. Nothing is published.
- Bits are sampled on posedge. The first word's b9 is sampled on the first posedge with enable_n=0.
- Latency: the command word's parity bit is sampled at posedge N; frame_valid=1 and all outputs are stable after posedge N.
- A frame of k data words takes 10*(k+1) cycles from first bit to frame_valid.
- Outputs hold stable from frame_valid rise until the transfer or an overwrite.
- Glitch-free registered outputs; no combinational path from din or enable_n to any output.

## Test plan
- Reset → all outputs 0. Assert rst_n=0 mid-word during a frame → no frame_valid, clean IDLE; the next frame is received correctly.
- Data 0x11, 0x22 then command 0x01 with correct parity, frame_ready=1 → frame_valid one cycle at 30 cycles after first bit; n_data=2, data[15:0]=0x2211, cmd=0x01, all errors 0.
- Command-only frame with cmd=0x05 → n_data=0, data=0, cmd=0x05. Repeat with the parity bit inverted → parity_err=1, cmd still 0x05.
- Nine data words 0x01..0x09 plus a command → n_data=8, byte7=0x08, overflow_err=1.
- enable_n rises after bit 4 of a data word → frame_valid with frame_err=1, cmd=0. Two data words then enable_n=1 at the boundary → frame_err=1, n_data=2.
- Two back-to-back frames (cmd 0x01, then 0x02) with frame_ready=0 → cmd=0x02 after the second completes, frame_valid stays 1. Raise frame_ready → frame_valid=0 the next cycle.
